// File: rtl/sparse_match_sequencer_pkg.sv
// Shared types and sizing for the sparse match sequencer: chunk width, index width,
// FSM state encoding and the layout of one match entry.
`ifndef PREFIX_SUM_SIZE
`define PREFIX_SUM_SIZE 8
`endif

package sparse_match_sequencer_pkg;

    localparam int CHUNK_SIZE_DEF = `PREFIX_SUM_SIZE;
    localparam int IDX_W_DEF      = $clog2(CHUNK_SIZE_DEF);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    typedef struct packed {
        logic [IDX_W_DEF-1:0] pos;
        logic [IDX_W_DEF-1:0] ifm_ofs;
        logic [IDX_W_DEF-1:0] flt_ofs;
        logic                 last;
    } match_entry_t;

endpackage

// File: rtl/sparse_match_sequencer_lsb_priority_encoder.sv
// Combinational least-significant-set-bit encoder; also reports whether any bit
// is set and whether exactly one bit is set.
module lsb_priority_encoder
    import sparse_match_sequencer_pkg::*;
#(
    parameter  int CHUNK_SIZE = CHUNK_SIZE_DEF,
    localparam int IDX_W      = $clog2(CHUNK_SIZE)
) (
    input  logic [CHUNK_SIZE-1:0] i_vector,
    output logic [IDX_W-1:0]      o_index,
    output logic                  o_any,
    output logic                  o_single
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        o_index = '0;
        for (int i = CHUNK_SIZE - 1; i >= 0; i--) begin
            if (i_vector[i]) begin
                o_index = IDX_W'(i);
            end
        end
    end

    assign o_any    = |i_vector;
    assign o_single = o_any && ((i_vector & (i_vector - CHUNK_SIZE'(1))) == '0);

endmodule

// File: rtl/sparse_match_sequencer.sv
// Sequences the AND of an IFM and filter sparsity bitmap into a back-pressurable
// stream of matched positions with prefix-sum offsets into both compressed buffers.
module sparse_match_sequencer
    import sparse_match_sequencer_pkg::*;
#(
    parameter  int CHUNK_SIZE = CHUNK_SIZE_DEF,
    localparam int IDX_W      = $clog2(CHUNK_SIZE),
    localparam int CNT_W      = IDX_W + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  flush_i,
    input  logic                  load_valid_i,
    output logic                  load_ready_o,
    input  logic [CHUNK_SIZE-1:0] ifm_map_i,
    input  logic [CHUNK_SIZE-1:0] flt_map_i,
    input  logic                  dense_flt_i,
    output logic                  match_valid_o,
    input  logic                  match_ready_i,
    output logic [IDX_W-1:0]      match_pos_o,
    output logic [IDX_W-1:0]      ifm_ofs_o,
    output logic [IDX_W-1:0]      flt_ofs_o,
    output logic                  match_last_o,
    output logic [CNT_W-1:0]      match_cnt_o,
    output logic                  done_o
);

    state_t                r_state;
    state_t                w_state_next;
    logic [CHUNK_SIZE-1:0] r_ifm;
    logic [CHUNK_SIZE-1:0] r_flt;
    logic [CHUNK_SIZE-1:0] r_mask;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_done;

    logic [CHUNK_SIZE-1:0] w_flt_in;
    logic [CHUNK_SIZE-1:0] w_mask_in;
    logic [CNT_W-1:0]      w_load_cnt;
    logic [IDX_W-1:0]      w_pos;
    logic                  w_any;
    logic                  w_single;
    logic [IDX_W-1:0]      w_ifm_ofs;
    logic [IDX_W-1:0]      w_flt_ofs;
    logic                  w_load_fire;
    logic                  w_match_fire;
    logic                  w_done_next;

    assign w_flt_in  = dense_flt_i ? '1 : flt_map_i;
    assign w_mask_in = ifm_map_i & w_flt_in;

    always_comb begin
        w_load_cnt = '0;
        for (int i = 0; i < CHUNK_SIZE; i++) begin
            w_load_cnt = w_load_cnt + CNT_W'(w_mask_in[i]);
        end
    end

    lsb_priority_encoder #(
        .CHUNK_SIZE (CHUNK_SIZE)
    ) u_lsb_enc (
        .i_vector (r_mask),
        .o_index  (w_pos),
        .o_any    (w_any),
        .o_single (w_single)
    );

    // Prefix sums below the current match; both collapse to zero when the mask is empty.
    always_comb begin
        w_ifm_ofs = '0;
        w_flt_ofs = '0;
        for (int i = 0; i < CHUNK_SIZE; i++) begin
            if (i < int'(w_pos)) begin
                w_ifm_ofs = w_ifm_ofs + IDX_W'(r_ifm[i]);
                w_flt_ofs = w_flt_ofs + IDX_W'(r_flt[i]);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Flush outranks both a load and a match handshake in the same cycle.
    always_comb begin
        w_state_next  = r_state;
        w_load_fire   = 1'b0;
        w_match_fire  = 1'b0;
        w_done_next   = 1'b0;
        load_ready_o  = 1'b0;
        match_valid_o = 1'b0;
        case (r_state)
            IDLE: begin
                load_ready_o = 1'b1;
                if (!flush_i && load_valid_i) begin
                    w_load_fire = 1'b1;
                    if (w_mask_in == '0) begin
                        w_done_next = 1'b1;
                    end else begin
                        w_state_next = SCAN;
                    end
                end
            end
            SCAN: begin
                match_valid_o = 1'b1;
                if (flush_i) begin
                    w_state_next = IDLE;
                end else if (match_ready_i && w_any) begin
                    w_match_fire = 1'b1;
                    if (w_single) begin
                        w_state_next = IDLE;
                        w_done_next  = 1'b1;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ifm  <= '0;
            r_flt  <= '0;
            r_mask <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_done_next;
            if (flush_i) begin
                r_mask <= '0;
            end else if (w_load_fire) begin
                r_ifm  <= ifm_map_i;
                r_flt  <= w_flt_in;
                r_mask <= w_mask_in;
                r_cnt  <= w_load_cnt;
            end else if (w_match_fire) begin
                r_mask <= r_mask & ~(CHUNK_SIZE'(1) << w_pos);
            end
        end
    end

    assign match_pos_o  = w_pos;
    assign ifm_ofs_o    = w_ifm_ofs;
    assign flt_ofs_o    = w_flt_ofs;
    assign match_last_o = w_single;
    assign match_cnt_o  = r_cnt;
    assign done_o       = r_done;

endmodule

// File: tb/tb_sparse_match_sequencer.sv
// Directed bench for sparse_match_sequencer: stimulus pushes hand-computed match
// entries into a scoreboard that a negedge monitor checks against the match stream.
module tb_sparse_match_sequencer;
    import sparse_match_sequencer_pkg::*;

    logic       clk_i;
    logic       rst_n_i;
    logic       flush_i;
    logic       load_valid_i;
    logic       load_ready_o;
    logic [7:0] ifm_map_i;
    logic [7:0] flt_map_i;
    logic       dense_flt_i;
    logic       match_valid_o;
    logic       match_ready_i;
    logic [2:0] match_pos_o;
    logic [2:0] ifm_ofs_o;
    logic [2:0] flt_ofs_o;
    logic       match_last_o;
    logic [3:0] match_cnt_o;
    logic       done_o;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int d0;
    string phase = "reset";
    match_entry_t exp_q[$];
    match_entry_t mon_e;

    sparse_match_sequencer #(
        .CHUNK_SIZE (8)
    ) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .flush_i       (flush_i),
        .load_valid_i  (load_valid_i),
        .load_ready_o  (load_ready_o),
        .ifm_map_i     (ifm_map_i),
        .flt_map_i     (flt_map_i),
        .dense_flt_i   (dense_flt_i),
        .match_valid_o (match_valid_o),
        .match_ready_i (match_ready_i),
        .match_pos_o   (match_pos_o),
        .ifm_ofs_o     (ifm_ofs_o),
        .flt_ofs_o     (flt_ofs_o),
        .match_last_o  (match_last_o),
        .match_cnt_o   (match_cnt_o),
        .done_o        (done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s/%s: got %0d required %0d", phase, name, act, req);
        end
    endtask

    function automatic void push(input int pos, input int io, input int fo, input bit last);
        match_entry_t e;
        e.pos     = 3'(pos);
        e.ifm_ofs = 3'(io);
        e.flt_ofs = 3'(fo);
        e.last    = last;
        exp_q.push_back(e);
    endfunction

    task automatic do_load(input logic [7:0] ifm, input logic [7:0] flt, input logic dense);
        ifm_map_i    = ifm;
        flt_map_i    = flt;
        dense_flt_i  = dense;
        load_valid_i = 1'b1;
        @(posedge clk_i);
        #1 load_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk_i);
            if (load_ready_o) seen = 1'b1;
        end
        check("wait_idle_in_budget", 32'(seen), 32'd1);
    endtask

    // Monitor: every presented entry is compared with the scoreboard head; popped on handshake.
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_n_i) begin
                if (done_o) done_cnt++;
                if (match_valid_o && !flush_i) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL %s/unexpected_entry: got pos %0d required no entry", phase, match_pos_o);
                    end else begin
                        mon_e = exp_q[0];
                        check("pos", 32'(match_pos_o), 32'(mon_e.pos));
                        check("ifm_ofs", 32'(ifm_ofs_o), 32'(mon_e.ifm_ofs));
                        check("flt_ofs", 32'(flt_ofs_o), 32'(mon_e.flt_ofs));
                        check("last", 32'(match_last_o), 32'(mon_e.last));
                        if (match_ready_i) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_i       = 1'b1;
        flush_i       = 1'b0;
        load_valid_i  = 1'b0;
        ifm_map_i     = '0;
        flt_map_i     = '0;
        dense_flt_i   = 1'b0;
        match_ready_i = 1'b1;
        #1 rst_n_i = 1'b0;
        #1;
        check("rst_load_ready", 32'(load_ready_o), 32'd1);
        check("rst_valid", 32'(match_valid_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_cnt", 32'(match_cnt_o), 32'd0);
        check("rst_pos", 32'(match_pos_o), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Case 1: three matches, done one cycle after the last handshake.
        phase = "case1";
        push(1, 0, 1, 0); push(4, 2, 2, 0); push(7, 4, 4, 1);
        do_load(8'hB6, 8'hD3, 1'b0);
        repeat (3) @(negedge clk_i);
        @(negedge clk_i);
        check("done_pulse", 32'(done_o), 32'd1);
        check("load_ready", 32'(load_ready_o), 32'd1);
        check("valid_low", 32'(match_valid_o), 32'd0);
        check("cnt", 32'(match_cnt_o), 32'd3);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        @(negedge clk_i);
        check("done_one_cycle", 32'(done_o), 32'd0);

        // Case 2: no overlap, done the cycle after load.
        phase = "case2";
        do_load(8'h0F, 8'hF0, 1'b0);
        @(negedge clk_i);
        check("done_pulse", 32'(done_o), 32'd1);
        check("load_ready", 32'(load_ready_o), 32'd1);
        check("valid_low", 32'(match_valid_o), 32'd0);
        check("cnt", 32'(match_cnt_o), 32'd0);
        @(negedge clk_i);
        check("done_one_cycle", 32'(done_o), 32'd0);

        // Case 3: first entry stalled three cycles.
        phase = "case3";
        match_ready_i = 1'b0;
        push(1, 0, 1, 0); push(4, 2, 2, 0); push(7, 4, 4, 1);
        do_load(8'hB6, 8'hD3, 1'b0);
        repeat (3) @(posedge clk_i);
        #1 match_ready_i = 1'b1;
        wait_idle();
        check("cnt", 32'(match_cnt_o), 32'd3);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        // Case 4: dense filter.
        phase = "case4";
        d0 = done_cnt;
        push(0, 0, 0, 0); push(7, 1, 7, 1);
        do_load(8'h81, 8'h00, 1'b1);
        wait_idle();
        @(posedge clk_i);
        #1;
        check("cnt", 32'(match_cnt_o), 32'd2);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("done_count", 32'(done_cnt), 32'(d0 + 1));

        // Case 5: full chunk, load_ready back 9 cycles after load, next chunk taken at once.
        phase = "case5";
        for (int k = 0; k < 8; k++) push(k, k, k, k == 7);
        do_load(8'hFF, 8'hFF, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_i);
            check("busy", 32'(load_ready_o), 32'd0);
        end
        @(negedge clk_i);
        check("ready_after_9", 32'(load_ready_o), 32'd1);
        check("done_pulse", 32'(done_o), 32'd1);
        check("cnt_full", 32'(match_cnt_o), 32'd8);
        push(0, 0, 0, 0); push(7, 1, 7, 1);
        do_load(8'h81, 8'h00, 1'b1);
        @(negedge clk_i);
        check("back_to_back_valid", 32'(match_valid_o), 32'd1);
        wait_idle();
        check("cnt", 32'(match_cnt_o), 32'd2);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        // Case 6a: flush after the second entry, then flush beating a load.
        phase = "flush";
        @(posedge clk_i);
        #1;
        push(1, 0, 1, 0); push(4, 2, 2, 0);
        do_load(8'hB6, 8'hD3, 1'b0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1 flush_i = 1'b1;
        @(posedge clk_i);
        #1 flush_i = 1'b0;
        d0 = done_cnt;
        @(negedge clk_i);
        check("valid_low", 32'(match_valid_o), 32'd0);
        check("load_ready", 32'(load_ready_o), 32'd1);
        check("no_done", 32'(done_o), 32'd0);
        check("cnt_held", 32'(match_cnt_o), 32'd3);
        check("pos_zero", 32'(match_pos_o), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk_i);
        check("no_done_later", 32'(done_cnt), 32'(d0));
        @(posedge clk_i);
        #1;
        flush_i      = 1'b1;
        ifm_map_i    = 8'h81;
        flt_map_i    = 8'h00;
        dense_flt_i  = 1'b1;
        load_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i      = 1'b0;
        load_valid_i = 1'b0;
        @(negedge clk_i);
        check("flush_beats_load_valid", 32'(match_valid_o), 32'd0);
        check("flush_beats_load_cnt", 32'(match_cnt_o), 32'd3);
        check("flush_beats_load_done", 32'(done_o), 32'd0);

        // Case 6b: asynchronous reset in the middle of a stalled scan.
        phase = "reset_mid_scan";
        match_ready_i = 1'b0;
        for (int k = 0; k < 8; k++) push(k, k, k, k == 7);
        do_load(8'hFF, 8'hFF, 1'b0);
        @(negedge clk_i);
        d0 = done_cnt;
        #2 rst_n_i = 1'b0;
        #1;
        check("valid_low", 32'(match_valid_o), 32'd0);
        check("load_ready", 32'(load_ready_o), 32'd1);
        check("cnt_zero", 32'(match_cnt_o), 32'd0);
        check("pos_zero", 32'(match_pos_o), 32'd0);
        check("ifm_ofs_zero", 32'(ifm_ofs_o), 32'd0);
        check("last_zero", 32'(match_last_o), 32'd0);
        check("done_low", 32'(done_o), 32'd0);
        exp_q.delete();
        @(negedge clk_i);
        rst_n_i       = 1'b1;
        match_ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check("no_done_after_reset", 32'(done_cnt), 32'(d0));
        check("idle_after_reset", 32'(match_valid_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sparse_match_sequencer.md
Name: sparse_match_sequencer

Overview:
Takes one chunk of IFM and filter sparsity bitmaps. ANDs them to find positions where both operands are non-zero. Emits one matched position per cycle over a valid/ready stream. Each match carries prefix-sum offsets into the compressed IFM and filter value buffers. It sits between the bitmap fetch stage and the MAC lane, and replaces the purely combinational bitmap AND with a sequenced, back-pressurable match stream.

Parameters:
CHUNK_SIZE, `PREFIX_SUM_SIZE, bits per bitmap chunk (>=2)
IDX_W, $clog2(CHUNK_SIZE), width of position/offset fields (derived, not overridden)

Ports:
clk_i  in  1  clock, all logic rising-edge
rst_n_i  in  1  asynchronous, active-low reset
flush_i  in  1  synchronous abort of current chunk
load_valid_i  in  1  new chunk offered
load_ready_o  out  1  block can accept a chunk
ifm_map_i  in  CHUNK_SIZE  IFM non-zero bitmap
flt_map_i  in  CHUNK_SIZE  filter non-zero bitmap
dense_flt_i  in  1  1 = filter dense; treat flt_map_i as all ones
match_valid_o  out  1  match entry valid
match_ready_i  in  1  consumer accepts entry
match_pos_o  out  IDX_W  bit position of match
ifm_ofs_o  out  IDX_W  count of IFM ones below match_pos_o
flt_ofs_o  out  IDX_W  count of filter ones below match_pos_o (= match_pos_o in dense mode)
match_last_o  out  1  entry is the final match of the chunk
match_cnt_o  out  IDX_W+1  total matches in the current or last chunk
done_o  out  1  one-cycle pulse when a chunk completes

Behaviour:
- Reset (async assert, sync deassert as seen by logic):
  - state=IDLE; all registers 0.
  - load_ready_o=1, match_valid_o=0, done_o=0, match_cnt_o=0, all data outputs 0.
- States: IDLE, SCAN.
- IDLE:
  - load_ready_o=1, match_valid_o=0.
  - On load_valid_i&load_ready_o, register:
    - ifm_q=ifm_map_i
    - flt_q = dense_flt_i ? all ones : flt_map_i
    - mask_q = ifm_q & flt_q
    - match_cnt_o = popcount(mask)
  - Next state: mask==0 → stay IDLE, done_o=1 next cycle. Otherwise → SCAN.
- SCAN:
  - load_ready_o=0, match_valid_o=1.
  - match_pos_o = index of least-significant set bit of mask_q.
  - ifm_ofs_o = popcount(ifm_q & ((1<<pos)-1)); flt_ofs_o likewise on flt_q.
  - match_last_o=1 when mask_q has exactly one bit set.
  - Data outputs are combinational from registers only. There is no path from match_ready_i to any output.
- Handshake (match_valid_o&match_ready_i): clear that bit of mask_q.
  - If match_last_o, go to IDLE and pulse done_o the following cycle.
- Back-pressure: while valid & !ready, all match outputs hold stable.
- Latency: load accepted in cycle N → first match_valid_o in N+1. With ready held high, one match per cycle. A chunk with M matches frees load_ready_o in cycle N+1+M.
- flush_i (any state):
  - Next cycle: IDLE, mask_q=0, match_valid_o=0, no done_o.
  - match_cnt_o holds its value.
  - flush_i has priority over a same-cycle load or match handshake; the load is not accepted and load_ready_o is ignored that cycle.
- Full chunk (all ones): CHUNK_SIZE matches, positions 0..CHUNK_SIZE-1; match_cnt_o=CHUNK_SIZE, hence IDX_W+1 bits.
- Offsets never exceed CHUNK_SIZE-1, so no overflow is possible.
- Reset mid-SCAN: outputs return to reset values immediately; no done_o.

Decomposition:
- Shared package: CHUNK_SIZE default (from `PREFIX_SUM_SIZE), IDX_W derivation, state enum {IDLE, SCAN}, match-entry struct {pos, ifm_ofs, flt_ofs, last}.
- One sub-module: lsb_priority_encoder.
  - Parameter: CHUNK_SIZE.
  - Inputs: vector. Outputs: index, any, single.
  - Purely combinational. Instantiated once on mask_q.
- Popcounts stay inline.

Test Plan (CHUNK_SIZE=8):
1. ifm=8'b1011_0110, flt=8'b1101_0011, dense=0, ready high → three matches (pos,ifm_ofs,flt_ofs): (1,0,1), (4,2,2), (7,4,4); last only on pos 7; match_cnt_o=3; done_o one cycle after the third handshake.
2. ifm=8'h0F, flt=8'hF0 → match_valid_o never asserts; match_cnt_o=0; done_o pulses the cycle after load; load_ready_o stays 1.
3. Case-1 chunk with match_ready_i low for 3 cycles on the first entry → pos=1, ofs=(0,1) held stable all 3 cycles; sequence then continues unchanged.
4. ifm=8'h81, flt=8'h00, dense=1 → (0,0,0) then (7,1,7,last); match_cnt_o=2.
5. ifm=flt=8'hFF, ready high → 8 back-to-back entries, pos=ifm_ofs=flt_ofs=0..7; load_ready_o returns 9 cycles after load; next chunk accepted that cycle.
6. Flush and reset:
   - flush_i after the second entry of case 1 → next cycle IDLE, no further entries, no done_o.
   - rst_n_i low mid-scan → outputs at reset values asynchronously.
